// File: rtl/sc_proc_mem_sequencer_pkg.sv
// Shared types and constants for the SC processor memory sequencer.
// Imported by the interface, the watchdog and the sequencer top.
package sc_proc_pkg;

   localparam int DEF_DBITS = 32;
   localparam int WAIT_W    = 16;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      DATA,
      COMMIT,
      FAULT
   } seq_state_t;

endpackage

// File: rtl/sc_proc_mem_sequencer_if.sv
// Shared memory port between the sequencer (master) and memory (slave).
// One request in flight; ack marks completion and valid read data.
interface sc_proc_mem_sequencer_if
   import sc_proc_pkg::*;
#(
   parameter int DBITS = DEF_DBITS
);

   logic             mem_req;
   logic             mem_we;
   logic [DBITS-1:0] mem_addr;
   logic [DBITS-1:0] mem_wdata;
   logic             mem_ack;
   logic [DBITS-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/sc_proc_mem_sequencer_watchdog.sv
// Wait-cycle counter for the shared memory port.
// expired is high on the cycle whose edge would bring the count to TIMEOUT.
module sc_wait_watchdog
   import sc_proc_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

   logic [WAIT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (count_en) begin
         cnt <= cnt + WAIT_W'(1);
      end
   end

   assign expired = count_en && (cnt == LAST);

endmodule

// File: rtl/sc_proc_mem_sequencer.sv
// Fetch/decode/data/commit sequencer sharing one memory port.
// Emits a one-cycle lock strobe per retired instruction.
module sc_proc_mem_sequencer
   import sc_proc_pkg::*;
#(
   parameter int DBITS   = DEF_DBITS,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DBITS-1:0]        pc,
   input  logic                    is_load,
   input  logic                    is_store,
   input  logic [DBITS-1:0]        data_addr,
   input  logic [DBITS-1:0]        store_data,
   sc_proc_mem_sequencer_if.master mem,
   output logic [DBITS-1:0]        instr,
   output logic [DBITS-1:0]        load_data,
   output logic                    lock,
   output logic                    fault,
   output logic [31:0]             retired
);

   seq_state_t state;
   seq_state_t next;

   logic [DBITS-1:0] instr_q;
   logic [DBITS-1:0] load_q;
   logic [DBITS-1:0] addr_q;
   logic [DBITS-1:0] wdata_q;
   logic             we_q;
   logic             ld_q;
   logic [31:0]      ret_q;

   logic in_mem;
   logic expired;

   assign in_mem = (state == FETCH) || (state == DATA);

   sc_wait_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk      (clk),
      .reset    (reset),
      .clear    (!in_mem || mem.mem_ack),
      .count_en (in_mem && !mem.mem_ack),
      .expired  (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next            = state;
      mem.mem_req     = 1'b0;
      mem.mem_we      = 1'b0;
      mem.mem_addr    = '0;
      mem.mem_wdata   = '0;
      lock            = 1'b0;
      fault           = 1'b0;
      unique case (state)
         FETCH: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = pc;
            if (mem.mem_ack) begin
               next = DECODE;
            end else if (expired) begin
               next = FAULT;
            end
         end
         DECODE: begin
            next = (is_load || is_store) ? DATA : COMMIT;
         end
         DATA: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = we_q;
            mem.mem_addr  = addr_q;
            mem.mem_wdata = wdata_q;
            if (mem.mem_ack) begin
               next = COMMIT;
            end else if (expired) begin
               next = FAULT;
            end
         end
         COMMIT: begin
            lock = 1'b1;
            next = FETCH;
         end
         FAULT: begin
            fault = 1'b1;
         end
         default: begin
            next = FETCH;
         end
      endcase
      // State is unknown until the first reset edge; keep outputs quiet.
      if (reset) begin
         mem.mem_req   = 1'b0;
         mem.mem_we    = 1'b0;
         mem.mem_addr  = '0;
         mem.mem_wdata = '0;
         lock          = 1'b0;
         fault         = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= '0;
         load_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         ld_q    <= 1'b0;
         ret_q   <= '0;
      end else begin
         if (state == FETCH && mem.mem_ack) begin
            instr_q <= mem.mem_rdata;
         end
         // Store wins when both decode flags are set.
         if (state == DECODE) begin
            we_q    <= is_store;
            ld_q    <= is_load && !is_store;
            addr_q  <= data_addr;
            wdata_q <= store_data;
         end
         if (state == DATA && mem.mem_ack && ld_q) begin
            load_q <= mem.mem_rdata;
         end
         if (state == COMMIT) begin
            ret_q <= ret_q + 32'd1;
         end
      end
   end

   assign instr     = reset ? '0 : instr_q;
   assign load_data = reset ? '0 : load_q;
   assign retired   = reset ? '0 : ret_q;

endmodule

// File: tb/tb_sc_proc_mem_sequencer.sv
// Randomized directed bench for sc_proc_mem_sequencer.
// Acts as the memory and tracks expected architectural results.
module tb_sc_proc_mem_sequencer;

   localparam int DB = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [DB-1:0] pc;
   logic          is_load;
   logic          is_store;
   logic [DB-1:0] data_addr;
   logic [DB-1:0] store_data;
   logic [DB-1:0] instr;
   logic [DB-1:0] load_data;
   logic          lock;
   logic          fault;
   logic [31:0]   retired;

   sc_proc_mem_sequencer_if #(.DBITS(DB)) mem ();

   sc_proc_mem_sequencer #(
      .DBITS   (DB),
      .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .is_load    (is_load),
      .is_store   (is_store),
      .data_addr  (data_addr),
      .store_data (store_data),
      .mem        (mem),
      .instr      (instr),
      .load_data  (load_data),
      .lock       (lock),
      .fault      (fault),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] ret_m;
   logic [31:0] ld_m;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b1;
      mem.mem_ack = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_req", mem.mem_req, 0);
      chk("rst_we", mem.mem_we, 0);
      chk("rst_addr", mem.mem_addr, 0);
      chk("rst_wdata", mem.mem_wdata, 0);
      chk("rst_instr", instr, 0);
      chk("rst_ldata", load_data, 0);
      chk("rst_lock", lock, 0);
      chk("rst_fault", fault, 0);
      chk("rst_ret", retired, 0);
      ret_m = '0;
      ld_m  = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // kind: 0 alu, 1 lw, 2 sw, 3 lw+sw flags (treated as store)
   task automatic run_instr(input int kind, input int fw,
                            input int dw, input logic [31:0] iw,
                            input logic [31:0] dd,
                            input logic [31:0] da,
                            input logic [31:0] sd,
                            input bit preload);
      bit ld;
      bit st;
      ld = (kind == 1) || (kind == 3);
      st = (kind == 2) || (kind == 3);
      for (int w = 0; w <= fw; w++) begin
         @(negedge clk);
         if (w == 0) pc = $urandom;
         mem.mem_ack   = (w == fw);
         mem.mem_rdata = (w == fw) ? iw : $urandom;
         #1;
         if (w == 0) chk("f_ret", retired, ret_m);
         chk("f_req", mem.mem_req, 1);
         chk("f_we", mem.mem_we, 0);
         chk("f_addr", mem.mem_addr, pc);
         chk("f_lock", lock, 0);
      end
      @(negedge clk);
      mem.mem_ack   = 1'($urandom_range(0, 1));
      mem.mem_rdata = $urandom;
      is_load       = ld;
      is_store      = st;
      data_addr     = da;
      store_data    = sd;
      #1;
      chk("d_req", mem.mem_req, 0);
      chk("d_lock", lock, 0);
      chk("d_instr", instr, iw);
      if (preload) begin
         force dut.ret_q = 32'hFFFF_FFFF;
         #1;
         release dut.ret_q;
         ret_m = 32'hFFFF_FFFF;
      end
      if (ld || st) begin
         for (int w = 0; w <= dw; w++) begin
            @(negedge clk);
            is_load       = 1'($urandom_range(0, 1));
            is_store      = 1'($urandom_range(0, 1));
            mem.mem_ack   = (w == dw);
            mem.mem_rdata = (w == dw) ? dd : $urandom;
            #1;
            chk("x_req", mem.mem_req, 1);
            chk("x_we", mem.mem_we, st);
            chk("x_addr", mem.mem_addr, da);
            chk("x_wdata", mem.mem_wdata, sd);
            chk("x_lock", lock, 0);
         end
      end
      if (ld && !st) ld_m = dd;
      ret_m = ret_m + 32'd1;
      @(negedge clk);
      mem.mem_ack = 1'($urandom_range(0, 1));
      #1;
      chk("c_lock", lock, 1);
      chk("c_req", mem.mem_req, 0);
      chk("c_ldata", load_data, ld_m);
      chk("c_instr", instr, iw);
   endtask

   task automatic timeout_fetch();
      for (int w = 0; w < TO; w++) begin
         @(negedge clk);
         if (w == 0) pc = $urandom;
         mem.mem_ack = 1'b0;
         #1;
         chk("t_req", mem.mem_req, 1);
         chk("t_fault", fault, 0);
      end
      for (int w = 0; w < 6; w++) begin
         @(negedge clk);
         mem.mem_ack = 1'($urandom_range(0, 1));
         #1;
         chk("t_fault", fault, 1);
         chk("t_req", mem.mem_req, 0);
         chk("t_lock", lock, 0);
      end
   endtask

   task automatic reset_in_data();
      @(negedge clk);
      pc            = $urandom;
      mem.mem_ack   = 1'b1;
      mem.mem_rdata = $urandom;
      @(negedge clk);
      mem.mem_ack = 1'b0;
      is_load     = 1'b1;
      is_store    = 1'b0;
      data_addr   = $urandom;
      for (int w = 0; w < 2; w++) begin
         @(negedge clk);
         mem.mem_ack   = 1'b0;
         mem.mem_rdata = $urandom;
         #1;
         chk("r_req", mem.mem_req, 1);
         chk("r_lock", lock, 0);
      end
      do_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      pc            = '0;
      is_load       = 1'b0;
      is_store      = 1'b0;
      data_addr     = '0;
      store_data    = '0;
      mem.mem_ack   = 1'b0;
      mem.mem_rdata = '0;
      ret_m         = '0;
      ld_m          = '0;
      do_reset();
      run_instr(0, 0, 0, 32'h1234ABCD, 0, 0, 0, 0);
      run_instr(1, 0, 2, $urandom, 32'hDEADBEEF,
                32'h40, $urandom, 0);
      run_instr(2, 1, 1, $urandom, $urandom,
                32'h80, 32'hCAFEF00D, 0);
      for (int i = 0; i < 40; i++) begin
         run_instr($urandom_range(0, 3),
                   $urandom_range(0, TO - 1),
                   $urandom_range(0, TO - 1),
                   $urandom, $urandom, $urandom,
                   $urandom, 0);
      end
      timeout_fetch();
      do_reset();
      run_instr(1, 1, 0, $urandom, $urandom,
                $urandom, $urandom, 0);
      reset_in_data();
      run_instr(0, 0, 0, $urandom, 0, 0, 0, 0);
      run_instr(0, 0, 0, $urandom, 0, 0, 0, 1);
      @(negedge clk);
      mem.mem_ack = 1'b0;
      #1;
      chk("wrap_ret", retired, ret_m);
      chk("wrap_zero", retired, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
